// File: rtl/serial_slave_bridge_if.sv
// Serial system bus plus parallel peripheral port of the serial slave bridge.
// slave is the bridge's view, master the serial bus master, periph the peripheral.
interface serial_slave_bridge_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LANES      = 1
) ();

   logic                  mode;
   logic                  m_valid;
   logic                  m_ready;
   logic [LANES-1:0]      wr_bus;
   logic [LANES-1:0]      rd_bus;
   logic                  s_ready;
   logic                  s_valid;
   logic                  split;
   logic                  frame_err;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_ready;

   modport slave (
      input  mode, m_valid, m_ready, wr_bus, req_ready, rsp_valid, rsp_rdata,
      output rd_bus, s_ready, s_valid, split, frame_err,
             req_valid, req_write, req_addr, req_wdata, rsp_ready
   );

   modport master (
      output mode, m_valid, m_ready, wr_bus,
      input  rd_bus, s_ready, s_valid, split, frame_err
   );

   modport periph (
      output req_ready, rsp_valid, rsp_rdata,
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready
   );

endinterface

// File: rtl/serial_slave_bridge.sv
// Slave-side bridge: deserialises address/write data, issues a parallel request,
// serialises read data back and raises a split when the response is late.
module serial_slave_bridge #(
   parameter int unsigned ADDR_WIDTH    = 16,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned LANES         = 1,
   parameter int unsigned SPLIT_EN      = 1,
   parameter int unsigned SPLIT_TIMEOUT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_slave_bridge_if.slave bus
);

   localparam int unsigned AB   = ADDR_WIDTH / LANES;
   localparam int unsigned DB   = DATA_WIDTH / LANES;
   localparam int unsigned MAXB = (AB > DB) ? AB : DB;
   localparam int unsigned CW   = $clog2(MAXB + 1);
   localparam int unsigned WW   = (SPLIT_TIMEOUT > 0) ? $clog2(SPLIT_TIMEOUT + 1) : 1;

   localparam logic [CW-1:0] AddrLast = CW'(AB - 1);
   localparam logic [CW-1:0] DataLast = CW'(DB - 1);
   localparam logic [WW-1:0] WaitMax  = WW'(SPLIT_TIMEOUT);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StData,
      StReq,
      StWait,
      StSplit,
      StSend
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         beat_q, beat_d;
   logic [WW-1:0]         wait_q, wait_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  mode_q, mode_d;
   logic                  ferr_q, ferr_d;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      mode_d  = mode_q;
      ferr_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            beat_d  = '0;
            wait_d  = '0;
            addr_d  = '0;
            wdata_d = '0;
            if (bus.m_valid) begin
               mode_d  = bus.mode;
               state_d = StAddr;
            end
         end

         StAddr: begin
            if (bus.m_valid) begin
               // MSB-first: earlier beats end up in the upper bits
               addr_d = ADDR_WIDTH'({addr_q, bus.wr_bus});
               if (beat_q == AddrLast) begin
                  beat_d  = '0;
                  state_d = mode_q ? StData : StReq;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end else begin
               ferr_d  = 1'b1;
               state_d = StIdle;
            end
         end

         StData: begin
            if (bus.m_valid) begin
               wdata_d = DATA_WIDTH'({wdata_q, bus.wr_bus});
               if (beat_q == DataLast) begin
                  beat_d  = '0;
                  state_d = StReq;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end else begin
               ferr_d  = 1'b1;
               state_d = StIdle;
            end
         end

         StReq: begin
            if (bus.req_ready) begin
               state_d = mode_q ? StIdle : StWait;
            end
         end

         StWait: begin
            if (bus.rsp_valid) begin
               rdata_d = bus.rsp_rdata;
               state_d = StSend;
            end else if ((SPLIT_EN != 0) && (wait_q == WaitMax)) begin
               state_d = StSplit;
            end else if (wait_q != WaitMax) begin
               wait_d = wait_q + 1'b1;
            end
         end

         StSplit: begin
            if (bus.rsp_valid) begin
               rdata_d = bus.rsp_rdata;
               state_d = StSend;
            end
         end

         StSend: begin
            if (bus.m_ready) begin
               // Shift the next beat into the top lanes; drains to zero by the end
               rdata_d = DATA_WIDTH'({rdata_q, {LANES{1'b0}}});
               if (beat_q == DataLast) begin
                  beat_d  = '0;
                  state_d = StIdle;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         beat_q  <= '0;
         wait_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         mode_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         mode_q  <= mode_d;
         ferr_q  <= ferr_d;
      end
   end

   assign bus.s_ready   = (state_q == StAddr) || (state_q == StData);
   assign bus.s_valid   = (state_q == StSend);
   assign bus.split     = (state_q == StSplit);
   assign bus.req_valid = (state_q == StReq);
   assign bus.rsp_ready = (state_q == StWait) || (state_q == StSplit);
   assign bus.frame_err = ferr_q;
   assign bus.req_write = mode_q;
   assign bus.req_addr  = addr_q;
   assign bus.req_wdata = wdata_q;
   assign bus.rd_bus    = (state_q == StSend) ? rdata_q[DATA_WIDTH-1 -: LANES] : '0;

endmodule

// File: tb/tb_serial_slave_bridge.sv
// Randomised bench for serial_slave_bridge: a 1-lane split-enabled bridge and a
// 4-lane split-disabled bridge, both checked against a frame-level model.
module tb_serial_slave_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       sel;  // 0 selects the 1-lane bridge, 1 the 4-lane bridge
   logic       mode, m_valid, m_ready, req_ready, rsp_valid;
   logic [3:0] wbits;
   logic [7:0] rsp_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   serial_slave_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LANES(1)) bus1 ();
   serial_slave_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LANES(4)) bus4 ();

   assign bus1.mode      = mode;
   assign bus1.m_valid   = m_valid & ~sel;
   assign bus1.m_ready   = m_ready & ~sel;
   assign bus1.wr_bus    = wbits[0:0];
   assign bus1.req_ready = req_ready & ~sel;
   assign bus1.rsp_valid = rsp_valid & ~sel;
   assign bus1.rsp_rdata = rsp_rdata;

   assign bus4.mode      = mode;
   assign bus4.m_valid   = m_valid & sel;
   assign bus4.m_ready   = m_ready & sel;
   assign bus4.wr_bus    = wbits;
   assign bus4.req_ready = req_ready & sel;
   assign bus4.rsp_valid = rsp_valid & sel;
   assign bus4.rsp_rdata = rsp_rdata;

   serial_slave_bridge #(
      .ADDR_WIDTH(16), .DATA_WIDTH(8), .LANES(1), .SPLIT_EN(1), .SPLIT_TIMEOUT(4)
   ) u_dut1 (
      .clk(clk),
      .rst(rst),
      .bus(bus1)
   );

   serial_slave_bridge #(
      .ADDR_WIDTH(16), .DATA_WIDTH(8), .LANES(4), .SPLIT_EN(0), .SPLIT_TIMEOUT(2)
   ) u_dut4 (
      .clk(clk),
      .rst(rst),
      .bus(bus4)
   );

   logic        o_s_ready, o_s_valid, o_split, o_ferr, o_req_valid, o_req_write, o_rsp_ready;
   logic [3:0]  o_rd;
   logic [15:0] o_addr;
   logic [7:0]  o_wdata;

   always_comb begin
      if (sel) begin
         o_s_ready   = bus4.s_ready;
         o_s_valid   = bus4.s_valid;
         o_split     = bus4.split;
         o_ferr      = bus4.frame_err;
         o_req_valid = bus4.req_valid;
         o_req_write = bus4.req_write;
         o_rsp_ready = bus4.rsp_ready;
         o_rd        = bus4.rd_bus;
         o_addr      = bus4.req_addr;
         o_wdata     = bus4.req_wdata;
      end else begin
         o_s_ready   = bus1.s_ready;
         o_s_valid   = bus1.s_valid;
         o_split     = bus1.split;
         o_ferr      = bus1.frame_err;
         o_req_valid = bus1.req_valid;
         o_req_write = bus1.req_write;
         o_rsp_ready = bus1.rsp_ready;
         o_rd        = {3'b000, bus1.rd_bus};
         o_addr      = bus1.req_addr;
         o_wdata     = bus1.req_wdata;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t lanes=%0d)",
                  tag, act, exp, $time, sel ? 4 : 1);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int lanes();
      return sel ? 4 : 1;
   endfunction

   // Beat j (MSB first) of a w-bit value split into lanes()-bit beats
   function automatic logic [3:0] beat_of(input int unsigned v, input int w, input int j);
      int l;
      l = lanes();
      return 4'((v >> (w - l * (j + 1))) & ((32'd1 << l) - 32'd1));
   endfunction

   function automatic logic [63:0] all_out();
      return 64'({o_s_ready, o_s_valid, o_split, o_ferr, o_req_valid, o_req_write,
                  o_rsp_ready, o_rd, o_addr, o_wdata});
   endfunction

   task automatic do_reset();
      rst       = 1'b1;
      m_valid   = 1'b0;
      m_ready   = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      tick();
      check_eq("rst_outputs", all_out(), 64'd0);
      rst = 1'b0;
      tick();
      check_eq("rst_idle", all_out(), 64'd0);
   endtask

   // One frame. abort_at: beat index where m_valid drops (-1 none).
   // rst_phase: 1 resets in REQ, 2 resets in SEND. stall_mask bit j stalls beat j once.
   task automatic run_frame(input bit wr, input int unsigned addr, input int unsigned data,
                            input int req_dly, input int rsp_dly, input int abort_at,
                            input int rst_phase, input int unsigned stall_mask);
      int  nb_a, nb_d, total, j, guard;
      bit  exp_split, stalled, split_en;
      nb_a     = 16 / lanes();
      nb_d     = 8 / lanes();
      total    = wr ? nb_a + nb_d : nb_a;
      split_en = (sel == 1'b0);

      mode    = wr;
      m_valid = 1'b1;
      tick();
      mode = 1'($urandom);  // must have been latched already

      for (int i = 0; i < total; i++) begin
         if (i == abort_at) begin
            m_valid = 1'b0;
            tick();
            check_eq("abort_err", 64'({o_ferr, o_req_valid, o_s_ready}), 64'd4);
            tick();
            check_eq("abort_pulse", 64'({o_ferr, o_req_valid, o_s_ready}), 64'd0);
            return;
         end
         check_eq("rx_ready", 64'({o_s_ready, o_req_valid, o_s_valid}), 64'd4);
         wbits = (i < nb_a) ? beat_of(addr, 16, i) : beat_of(data, 8, i - nb_a);
         tick();
      end
      m_valid = 1'b0;
      wbits   = 4'h0;

      for (int k = 0; k <= req_dly; k++) begin
         req_ready = (k == req_dly);
         rsp_valid = 1'($urandom);
         rsp_rdata = 8'($urandom);
         check_eq("req_valid", 64'(o_req_valid), 64'd1);
         check_eq("req_fields",
                  64'({o_req_write, o_addr, o_wdata, o_rsp_ready, o_s_ready}),
                  64'({wr, addr[15:0], (wr ? data[7:0] : 8'h00), 2'b00}));
         if (rst_phase == 1 && k == 0) begin
            do_reset();
            return;
         end
         tick();
      end
      req_ready = 1'b0;
      rsp_valid = 1'b0;

      if (wr) begin
         check_eq("wr_done", 64'({o_req_valid, o_s_ready, o_rsp_ready, o_s_valid}), 64'd0);
         return;
      end

      for (int w = 0; w <= rsp_dly; w++) begin
         exp_split = split_en && (w > 4);
         check_eq("wait_state", 64'({o_split, o_rsp_ready, o_s_valid, o_req_valid}),
                  64'({exp_split, 3'b100}));
         rsp_valid = (w == rsp_dly);
         rsp_rdata = rsp_valid ? data[7:0] : 8'($urandom);
         tick();
      end

      j       = 0;
      guard   = 0;
      stalled = 1'b0;
      while (j < nb_d && guard < 64) begin
         check_eq("send_valid", 64'({o_s_valid, o_split, o_rsp_ready}), 64'd4);
         check_eq("send_beat", 64'(o_rd), 64'(beat_of(data, 8, j)));
         if (rst_phase == 2 && j == 1) begin
            do_reset();
            return;
         end
         m_ready   = !(stall_mask[j] && !stalled);
         rsp_valid = 1'($urandom);
         rsp_rdata = 8'($urandom);
         tick();
         guard++;
         if (m_ready) begin
            j++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
         end
      end
      m_ready   = 1'b0;
      rsp_valid = 1'b0;
      check_eq("send_done", 64'({o_s_valid, o_rd, o_split, o_rsp_ready}), 64'd0);
   endtask

   initial begin
      int unsigned ra, rd, mask;
      int          rq, rr, ab, rp;
      bit          rw;

      rst       = 1'b1;
      sel       = 1'b0;
      mode      = 1'b0;
      m_valid   = 1'b0;
      m_ready   = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = 8'h00;
      wbits     = 4'h0;
      tick();
      tick();
      check_eq("reset_state_l1", all_out(), 64'd0);
      sel = 1'b1;
      #1;
      check_eq("reset_state_l4", all_out(), 64'd0);
      sel = 1'b0;
      rst = 1'b0;
      tick();

      // 1-lane directed frames
      run_frame(1'b1, 32'hA5C3, 32'h5A, 3, 0, -1, 0, 0);
      tick();
      run_frame(1'b0, 32'h0012, 32'h3C, 0, 1, -1, 0, 32'h4);
      tick();
      run_frame(1'b0, 32'h0BEE, 32'hD2, 1, 10, -1, 0, 0);
      run_frame(1'b1, 32'h1111, 32'h22, 0, 0, 5, 0, 0);
      run_frame(1'b1, 32'h7E81, 32'h99, 0, 0, -1, 0, 0);
      run_frame(1'b1, 32'h4321, 32'h55, 0, 0, 20, 0, 0);
      run_frame(1'b0, 32'h2468, 32'hE1, 2, 3, -1, 2, 0);
      run_frame(1'b1, 32'h1357, 32'h0F, 2, 0, -1, 1, 0);
      run_frame(1'b0, 32'hFFFF, 32'hFF, 0, 0, -1, 0, 32'hFF);

      // 4-lane directed frames
      sel = 1'b1;
      tick();
      run_frame(1'b1, 32'h1234, 32'hAB, 0, 0, -1, 0, 0);
      run_frame(1'b0, 32'h00C0, 32'hC7, 0, 2, -1, 0, 32'h1);
      run_frame(1'b0, 32'h5555, 32'h81, 1, 9, -1, 0, 0);
      run_frame(1'b1, 32'h9999, 32'h66, 0, 0, 3, 0, 0);
      run_frame(1'b0, 32'h0A0A, 32'h3E, 1, 1, -1, 2, 0);

      for (int n = 0; n < 160; n++) begin
         sel  = 1'($urandom);
         rw   = 1'($urandom);
         ra   = $urandom_range(0, 32'hFFFF);
         rd   = $urandom_range(0, 32'hFF);
         rq   = $urandom_range(0, 3);
         rr   = $urandom_range(0, 9);
         mask = $urandom_range(0, 32'hFF);
         ab   = -1;
         rp   = 0;
         if ($urandom_range(0, 7) == 0) begin
            ab = $urandom_range(0, (rw ? 24 : 16) / (sel ? 4 : 1) - 1);
         end
         if ($urandom_range(0, 15) == 0) begin
            rp = $urandom_range(1, 2);
         end
         run_frame(rw, ra, rd, rq, rr, ab, rp, mask);
         if ($urandom_range(0, 1) == 1) begin
            tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_slave_bridge.md
# serial_slave_bridge

Parametrised slave-side bridge between the serial system bus and a parallel peripheral port, succeeding the single-bit UART slave bridge. It deserialises address and write data from the master over LANES bits per beat. It issues a parallel request with a valid/ready handshake and waits for the peripheral response. Read data is serialised back to the master; if the response is late, the bridge raises a split after a programmable timeout.

## Interface
- ADDR_WIDTH, 16, address bits per frame; must be a multiple of LANES
- DATA_WIDTH, 8, data bits per frame; must be a multiple of LANES
- LANES, 1, serial bits per beat on wr_bus/rd_bus (1, 2, 4 or 8)
- SPLIT_EN, 1, 1 allows the SPLIT state
- SPLIT_TIMEOUT, 4, WAIT cycles without a response before entering SPLIT (0 = split on the first empty WAIT cycle)
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- mode  in  1  1 = write frame, 0 = read frame; sampled in IDLE
- m_valid  in  1  master drives a valid beat
- m_ready  in  1  master accepts the current rd_bus beat
- wr_bus  in  LANES  master-to-slave serial data, MSB-first; lane LANES-1 is most significant
- rd_bus  out  LANES  slave-to-master serial data, MSB-first; 0 outside SEND
- s_ready  out  1  bridge is accepting address/data beats
- s_valid  out  1  rd_bus beat valid
- split  out  1  bridge has released the bus while awaiting a response
- frame_err  out  1  one-cycle pulse on an aborted frame
- req_valid  out  1  parallel request valid
- req_ready  in  1  peripheral accepts the request
- req_write  out  1  request type (latched mode)
- req_addr  out  ADDR_WIDTH  request address
- req_wdata  out  DATA_WIDTH  write data; 0 for reads
- rsp_valid  in  1  peripheral read data valid
- rsp_rdata  in  DATA_WIDTH  peripheral read data
- rsp_ready  out  1  bridge accepts the response

## Operation
- Beat counts: AB = ADDR_WIDTH/LANES, DB = DATA_WIDTH/LANES. The beat counter is $clog2(max(AB,DB)+1) bits wide. The WAIT counter saturates at SPLIT_TIMEOUT.
- States: IDLE, ADDR, DATA, REQ, WAIT, SPLIT, SEND.
- IDLE:
  - Clear the beat counter, the WAIT counter, req_addr and req_wdata.
  - If m_valid=1, latch mode and go to ADDR.
- ADDR (s_ready=1):
  - Each cycle with m_valid=1, shift wr_bus into req_addr from the MSB end and increment the beat counter.
  - On the AB-th beat, go to DATA if writing, else REQ. Reset the beat counter.
- DATA (s_ready=1): same as ADDR into req_wdata; after DB beats go to REQ.
- Abort: m_valid=0 in ADDR or DATA → pulse frame_err, go to IDLE, issue no request.
- REQ:
  - req_valid=1 and all req_* are held stable until req_ready=1.
  - On acceptance, a write goes to IDLE; a read goes to WAIT.
- WAIT (rsp_ready=1):
  - rsp_valid=1 → latch rsp_rdata and go to SEND.
  - Otherwise, if SPLIT_EN=1 and the WAIT counter equals SPLIT_TIMEOUT, go to SPLIT; else increment the counter.
  - With SPLIT_EN=0, the bridge waits indefinitely.
- SPLIT (split=1, rsp_ready=1): rsp_valid=1 → latch the data and go to SEND.
- SEND:
  - s_valid=1; rd_bus carries the current beat of the latched data, MSB beat first.
  - The beat counter advances only when m_ready=1. The last beat accepted → IDLE.
- rsp_valid is ignored (rsp_ready=0) outside WAIT and SPLIT.
- s_ready, s_valid, split, req_valid and rsp_ready are decoded from the registered state. frame_err is registered.

## Timing
- Reset: state IDLE; all outputs 0, including rd_bus, req_addr, req_wdata and frame_err.
- Reset mid-operation aborts the frame; no request is issued and no frame_err pulse is raised. The peripheral is reset by the same rst.
- Write, m_valid continuous: m_valid seen in IDLE at cycle 0; ADDR occupies cycles 1..AB; DATA occupies cycles AB+1..AB+DB; req_valid is first high at cycle AB+DB+1.
- Read: req_valid is first high at cycle AB+1.
- Response: captured in cycle t (rsp_valid & rsp_ready) → s_valid=1 at cycle t+1. A SEND with no stalls lasts DB cycles.
- Split: with no response, split rises in WAIT cycle index SPLIT_TIMEOUT+1, counting the first WAIT cycle as 0.
- frame_err is high for exactly the cycle after the abort cycle, coinciding with the return to IDLE.
- Back-to-back frames: one IDLE cycle minimum between frames.

## Test plan
- Write, LANES=1, addr 0xA5C3, data 0x5A, req_ready held low for 3 cycles → req_valid high from cycle 25 with req_addr=0xA5C3, req_wdata=0x5A, req_write=1, held stable; return to IDLE after acceptance.
- Read of addr 0x0012, rsp_rdata=0x3C one cycle after acceptance, m_ready low on the third beat → rd_bus=0,0,1,1,1,1,0,0 with the third bit held through the stall; s_valid drops after the 8th accepted beat.
- Read, SPLIT_EN=1, SPLIT_TIMEOUT=4, response 10 cycles after request acceptance → split asserted from WAIT cycle 5 until the response; then SEND of the correct data.
- Abort: m_valid drops after 5 address beats → single frame_err pulse, no req_valid; a following valid write completes normally.
- LANES=4: write addr 0x1234, data 0xAB as beats 1,2,3,4,A,B → req_valid at cycle 7; a read of 0xC7 returns beats C,7.
- rst asserted mid-SEND and mid-REQ → all outputs 0 in the following cycle; state IDLE.
